time_entry_loader: RTL

Front-end writer for the microwave timer counter chain (min-ones, sec-tens, sec-ones mod-10/mod-6 down counters). Captures keypad digits into a 3-digit BCD entry register (M:SS, right-shift-in). On start, it drives the counters' parallel-load interface (data, loadn), then gates their count enable. It monitors the chain's zero flag to detect end of cook, and handles pause, resume and clear.

---
 rtl/time_entry_loader_pkg.sv | 26 ++
 rtl/time_entry_loader_bcd_entry_reg.sv | 46 ++++
 rtl/time_entry_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/time_entry_loader_pkg.sv
// ----------------------------------------------------------------------------
// time_entry_loader_pkg
// Shared definitions for the microwave time-entry front end.
//   - state_t            : FSM state codes (ENTRY/LOAD/RUN/PAUSE)
//   - KEY_DIGIT_MAX      : largest keypad code treated as a digit
//   - SEC_TENS_MAX_DEFAULT / DIGITS_DEFAULT : default parameter values
//   - is_digit()         : keypad code classifier
// ----------------------------------------------------------------------------
package time_entry_loader_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [3:0] KEY_DIGIT_MAX        = 4'd9;
    localparam int         SEC_TENS_MAX_DEFAULT = 5;
    localparam int         DIGITS_DEFAULT       = 3;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= KEY_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/time_entry_loader_bcd_entry_reg.sv
// ----------------------------------------------------------------------------
// bcd_entry_reg
// DIGITS-wide BCD entry register, right-shift-in (new digit enters the least
// significant position, the most significant digit falls off the top).
// Ports:
//   clock, clrn       : clock (rising edge), async active-low reset
//   shift_en          : shift shift_digit in this cycle
//   shift_digit [3:0] : BCD digit to shift in
//   clear             : synchronous clear (wins over shift_en)
//   digits            : {min_ones, sec_tens, sec_ones} for DIGITS=3
//   all_zero          : every digit is zero
//   sec_tens_ok       : seconds-tens digit <= SEC_TENS_MAX
// ----------------------------------------------------------------------------
module bcd_entry_reg
    import time_entry_loader_pkg::*;
#(
    parameter int DIGITS       = DIGITS_DEFAULT,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEFAULT
) (
    input  logic                  clock,
    input  logic                  clrn,
    input  logic                  shift_en,
    input  logic [3:0]            shift_digit,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  all_zero,
    output logic                  sec_tens_ok
);

    localparam logic [3:0] TENS_MAX = 4'(SEC_TENS_MAX);

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            digits <= '0;
        end else if (clear) begin
            digits <= '0;
        end else if (shift_en) begin
            digits <= {digits[4*DIGITS-5:0], shift_digit};
        end
    end

    assign all_zero    = (digits == '0);
    // Digit 1 is always seconds-tens regardless of how many minute digits sit above it.
    assign sec_tens_ok = (digits[7:4] <= TENS_MAX);

endmodule

// File: rtl/time_entry_loader.sv
// ----------------------------------------------------------------------------
// time_entry_loader
// Front-end writer for the microwave timer down-counter chain. Collects keypad
// digits into an M:SS BCD entry register, parallel-loads the counter chain on
// start, gates its count enable, watches the chain zero flag for end of cook,
// and handles pause/resume/clear.
// Ports:
//   clock, clrn   : clock (rising edge), async active-low reset
//   keyvalid, key : one-cycle key strobe and keypad code (0-9 digits, others ignored)
//   startn, stopn : active-low one-cycle start/resume and stop/clear requests
//   zero          : counter chain all-zero flag
//   door_open     : door switch, present only with DOOR_INTERLOCK_EN defined
//   loadn, data   : active-low parallel load and BCD load value to the chain
//   enable        : counter chain count enable
//   done          : cook-complete flag
//   err           : one-cycle pulse when a start is rejected
//   state         : FSM state (0 ENTRY, 1 LOAD, 2 RUN, 3 PAUSE)
// Build option: DOOR_INTERLOCK_EN adds the door_open interlock.
// Control semantics: key/start/stop are single-cycle strobes with no
// back-pressure; a strobe is acted on only in the cycle it is asserted and
// only if the current state accepts it, otherwise it is dropped.
// All outputs are registered.
// ----------------------------------------------------------------------------
module time_entry_loader
    import time_entry_loader_pkg::*;
#(
    parameter int DIGITS       = DIGITS_DEFAULT,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEFAULT
) (
    input  logic                clock,
    input  logic                clrn,
    input  logic                keyvalid,
    input  logic [3:0]          key,
    input  logic                startn,
    input  logic                stopn,
    input  logic                zero,
`ifdef DOOR_INTERLOCK_EN
    input  logic                door_open,
`endif
    output logic                loadn,
    output logic [4*DIGITS-1:0] data,
    output logic                enable,
    output logic                done,
    output logic                err,
    output logic [1:0]          state
);

    localparam int W = 4*DIGITS;

    state_t         state_q, state_d;
    logic [W-1:0]   digits;
    logic           all_zero, tens_ok;
    logic           door_block;

    // Decoded actions from the next-state logic.
    logic shift_en, clear_digits, clear_data, capture, reject, set_done, clear_done;

    logic           loadn_d, enable_d, done_d, err_d;
    logic [W-1:0]   data_d;

    logic start, stop, key_ok;
    assign start  = !startn;
    assign stop   = !stopn;
    assign key_ok = keyvalid && is_digit(key);

`ifdef DOOR_INTERLOCK_EN
    assign door_block = door_open;
`else
    assign door_block = 1'b0;
`endif

    bcd_entry_reg #(
        .DIGITS       (DIGITS),
        .SEC_TENS_MAX (SEC_TENS_MAX)
    ) u_entry (
        .clock       (clock),
        .clrn        (clrn),
        .shift_en    (shift_en),
        .shift_digit (key),
        .clear       (clear_digits),
        .digits      (digits),
        .all_zero    (all_zero),
        .sec_tens_ok (tens_ok)
    );

    // State and output registers.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_ENTRY;
            loadn   <= 1'b1;
            data    <= '0;
            enable  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            loadn   <= loadn_d;
            data    <= data_d;
            enable  <= enable_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // Next-state and action decode. Priorities: stop beats start beats key;
    // in RUN, zero beats stop.
    always_comb begin
        state_d      = state_q;
        shift_en     = 1'b0;
        clear_digits = 1'b0;
        clear_data   = 1'b0;
        capture      = 1'b0;
        reject       = 1'b0;
        set_done     = 1'b0;
        clear_done   = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (stop) begin
                    clear_digits = 1'b1;
                    clear_data   = 1'b1;
                    clear_done   = 1'b1;
                end else if (start) begin
                    clear_done = 1'b1;
                    if (!all_zero && tens_ok && !door_block) begin
                        state_d = ST_LOAD;
                        capture = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (key_ok) begin
                    shift_en   = 1'b1;
                    clear_done = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (zero) begin
                    state_d      = ST_ENTRY;
                    clear_digits = 1'b1;
                    set_done     = 1'b1;
                end else if (stop || door_block) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d      = ST_ENTRY;
                    clear_digits = 1'b1;
                    clear_data   = 1'b1;
                end else if (start) begin
                    if (door_block) reject  = 1'b1;
                    else            state_d = ST_RUN;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    // Registered outputs follow the state being entered, so loadn is low for
    // exactly the LOAD cycle and enable is high exactly while in RUN.
    always_comb begin
        loadn_d  = (state_d != ST_LOAD);
        enable_d = (state_d == ST_RUN);
        err_d    = reject;
        done_d   = done;
        if (set_done)        done_d = 1'b1;
        else if (clear_done) done_d = 1'b0;
        data_d   = data;
        if (capture)         data_d = digits;
        else if (clear_data) data_d = '0;
    end

    assign state = state_q;

endmodule
